addsub_serial_ctrl: RTL and testbench

//   Sequencer for the shared add/subtract full-adder slice (s = a^bn^c,
//   c' = ((a^bn)&c)|(a&bn), bn = b^sub).
//   - Accepts one WIDTH-bit add or subtract request per valid/ready handshake.
//   - Runs the single slice LSB-first, one bit per clock.
//   - Returns sum, carry-out and signed overflow on a valid/ready result port.
//   - Lets one 1-bit adder serve any operand width, with defined latency.

---
 rtl/addsub_serial_ctrl_if.sv | 32 +++
 rtl/addsub_serial_ctrl.sv | 127 ++++++++++++
 tb/tb_addsub_serial_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/addsub_serial_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : addsub_serial_ctrl_if
// Description : Request/result handshake bundle for the serial add/sub sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface addsub_serial_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_s;
    logic             o_c;
    logic             o_ovf;
    logic             o_busy;

    modport master (
        output i_valid, i_a, i_b, i_sub, i_ready,
        input  o_ready, o_valid, o_s, o_c, o_ovf, o_busy
    );

    modport slave (
        input  i_valid, i_a, i_b, i_sub, i_ready,
        output o_ready, o_valid, o_s, o_c, o_ovf, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/addsub_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : addsub_serial_ctrl
// Description : Bit-serial (LSB-first) add/subtract sequencer around one
//               full-adder slice, with valid/ready request and result ports.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_serial_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  wire                   i_clk,
    input  wire                   i_rst_n,
    addsub_serial_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_sr_q,  a_sr_d;
    logic [WIDTH-1:0] b_sr_q,  b_sr_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q,     s_d;
    logic             c_q,     c_d;
    logic             ovf_q,   ovf_d;
    logic             valid_q, valid_d;

    logic             w_sum;
    logic             w_cout;

    // The shared full-adder slice; b_sr already holds B ^ {WIDTH{sub}}.
    assign w_sum  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign w_cout = ((a_sr_q[0] ^ b_sr_q[0]) & carry_q) | (a_sr_q[0] & b_sr_q[0]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        s_d     = s_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    a_sr_d  = bus.i_a;
                    b_sr_d  = bus.i_b ^ {WIDTH{bus.i_sub}};
                    carry_d = bus.i_sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = w_cout;
                res_d   = {w_sum, res_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == c_LAST) begin
                    // carry_q here is the carry into the MSB position
                    s_d     = {w_sum, res_q[WIDTH-1:1]};
                    c_d     = w_cout;
                    ovf_d   = carry_q ^ w_cout;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.o_ready = (state_q == ST_IDLE);
    assign bus.o_busy  = (state_q == ST_RUN);
    assign bus.o_valid = valid_q;
    assign bus.o_s     = s_q;
    assign bus.o_c     = c_q;
    assign bus.o_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_serial_ctrl
// Description : Scoreboard bench for addsub_serial_ctrl (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_serial_ctrl;

    localparam int c_W = 4;

    typedef struct {
        logic [c_W-1:0] s;
        logic           c;
        logic           ovf;
        int             acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    int   last_hs;
    int   last_acc;
    logic prev_valid;
    exp_t sb[$];

    addsub_serial_ctrl_if #(.WIDTH(c_W)) bus ();

    addsub_serial_ctrl #(.WIDTH(c_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                                  input logic sub, output logic [c_W-1:0] s,
                                  output logic c, output logic ovf);
        logic [c_W:0]   t;
        logic [c_W-1:0] bb;
        bb  = sub ? ~b : b;
        t   = {1'b0, a} + {1'b0, bb} + {{c_W{1'b0}}, sub};
        s   = t[c_W-1:0];
        c   = t[c_W];
        ovf = sub ? ((a[c_W-1] != b[c_W-1]) && (s[c_W-1] != a[c_W-1]))
                  : ((a[c_W-1] == b[c_W-1]) && (s[c_W-1] != a[c_W-1]));
    endfunction

    // Monitor: compares every cycle the result is presented, pops on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(bus.o_valid), 32'd0);
                end else begin
                    if (!prev_valid)
                        check("latency", 32'(cyc - sb[0].acc), 32'(c_W));
                    check("o_s",   32'(bus.o_s),   32'(sb[0].s));
                    check("o_c",   32'(bus.o_c),   32'(sb[0].c));
                    check("o_ovf", 32'(bus.o_ovf), 32'(sb[0].ovf));
                    if (bus.i_ready) begin
                        void'(sb.pop_front());
                        last_hs = cyc + 1;
                    end
                end
            end
            prev_valid <= bus.o_valid;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    // mode: 0 plain, 1 expect acceptance one clock after last result handshake,
    //       2 expect WIDTH+2 spacing from previous acceptance
    task automatic send(input logic [c_W-1:0] a, input logic [c_W-1:0] b, input logic sub,
                        input logic [c_W-1:0] es, input logic ec, input logic eo, input int mode);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_sub   = sub;
        bus.i_valid = 1'b1;
        n = 0;
        while (!bus.o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.i_valid = 1'b0;
        end else begin
            e.s   = es;
            e.c   = ec;
            e.ovf = eo;
            e.acc = cyc + 1;
            sb.push_back(e);
            if (mode == 1) check("accept_gap", 32'(e.acc - last_hs), 32'd1);
            if (mode == 2) check("spacing", 32'(e.acc - last_acc), 32'(c_W + 2));
            last_acc = e.acc;
            @(posedge clk);
            #1;
            bus.i_valid = 1'b0;
            bus.i_a     = ~a;
            bus.i_b     = ~b;
            bus.i_sub   = ~sub;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !bus.o_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [c_W-1:0] ra, rb, ms;
        logic           rs, mc, mo;
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        last_hs     = 0;
        last_acc    = 0;
        prev_valid  = 1'b0;
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_sub   = 1'b0;
        bus.i_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_o_ready", 32'(bus.o_ready), 32'd1);
        check("rst_o_valid", 32'(bus.o_valid), 32'd0);
        check("rst_o_s",     32'(bus.o_s),     32'd0);
        check("rst_o_busy",  32'(bus.o_busy),  32'd0);
        rst_n = 1'b1;

        // Directed arithmetic
        send(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1, 0);
        send(4'b0111, 4'b0010, 1'b1, 4'b0101, 1'b1, 1'b0, 0);
        send(4'b0010, 4'b0111, 1'b1, 4'b1011, 1'b0, 1'b0, 0);
        send(4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1, 0);
        send(4'b0110, 4'b0110, 1'b1, 4'b0000, 1'b1, 1'b0, 0);
        wait_drain();

        // Back-pressure: result held 3 extra clocks, next request waits on it
        bus.i_ready = 1'b0;
        send(4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0, 0);
        fork
            send(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1);
            begin
                int n;
                n = 0;
                while (!bus.o_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_valid_seen", 32'(bus.o_valid), 32'd1);
                repeat (3) @(posedge clk);
                #1;
                bus.i_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset in the middle of RUN (cnt==2)
        send(4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(bus.o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check("mid_rst_o_valid", 32'(bus.o_valid), 32'd0);
        check("mid_rst_o_s",     32'(bus.o_s),     32'd0);
        check("mid_rst_o_c",     32'(bus.o_c),     32'd0);
        check("mid_rst_o_ovf",   32'(bus.o_ovf),   32'd0);
        check("mid_rst_o_busy",  32'(bus.o_busy),  32'd0);
        check("mid_rst_o_ready", 32'(bus.o_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send(4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0, 0);
        wait_drain();

        // Back-to-back requests against the reference model
        for (int i = 0; i < 16; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, ms, mc, mo);
            send(ra, rb, rs, ms, mc, mo, (i == 0) ? 0 : 2);
        end
        wait_drain();

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
